// File: rtl/plot_scheduler.sv
// plot_scheduler: time-multiplexes one VGA plot port between up to eight
// sprite draw units. Each frame_tick runs one pass: for every enabled sprite,
// in ascending index order, the unit is restarted once to erase its old image
// and once more to draw the new one. The scheduler forwards the unit's pixel
// stream to the plot port while it waits for the unit's done flag.
//
// Optional feature: define PLOT_SCHED_TIMEOUT_EN to add a wait-phase watchdog.
// A wait phase that lasts TIMEOUT cycles without done is forced to finish and
// sets the sticky timeout_err_o flag. Without the macro the wait phases wait
// indefinitely and timeout_err_o is tied low.
module plot_scheduler #(
  parameter int         NUM_SPRITES  = 7,
  parameter logic [2:0] DRAW_COLOUR  = 3'b111,
  parameter logic [2:0] ERASE_COLOUR = 3'b000,
  parameter int         TIMEOUT      = 32
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     frame_tick_i,
  input  logic [NUM_SPRITES-1:0]   sprite_en_i,
  input  logic [NUM_SPRITES-1:0]   done_i,
  input  logic [8*NUM_SPRITES-1:0] x_in_i,
  input  logic [7*NUM_SPRITES-1:0] y_in_i,
  output logic [NUM_SPRITES-1:0]   start_o,
  output logic [2:0]               sel_o,
  output logic [7:0]               plot_x_o,
  output logic [6:0]               plot_y_o,
  output logic [2:0]               colour_o,
  output logic                     plot_o,
  output logic                     busy_o,
  output logic                     pass_done_o,
  output logic                     overrun_o,
  output logic                     timeout_err_o
);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    E_START,
    E_WAIT,
    D_START,
    D_WAIT
  } state_t;

  state_t                 state_q;
  logic [NUM_SPRITES-1:0] pending_q;
  logic [2:0]             sel_q;
  logic [NUM_SPRITES-1:0] start_q;
  logic                   busy_q;
  logic                   pass_done_q;
  logic                   overrun_q;

  logic [2:0]             low_idx;
  logic [NUM_SPRITES-1:0] low_mask;
  logic [NUM_SPRITES-1:0] sel_mask;
  logic                   done_sel;
  logic                   in_wait;
  logic                   wait_expired;

  // Lowest pending sprite index, so disabled sprites cost no cycles.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    low_idx = 3'd0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        low_idx = 3'(i);
      end
    end
    low_mask = NUM_SPRITES'(1) << low_idx;
  end

  assign sel_mask = NUM_SPRITES'(1) << sel_q;
  assign done_sel = done_i[sel_q];
  assign in_wait  = (state_q == E_WAIT) || (state_q == D_WAIT);

`ifdef PLOT_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wdog_q;
  logic            timeout_err_q;

  assign wait_expired  = !done_sel && (wdog_q == WD_W'(TIMEOUT - 1));
  assign timeout_err_o = timeout_err_q;

  // Watchdog: cleared in each start state, counts wait cycles, flags expiry.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if ((state_q == E_START) || (state_q == D_START)) begin
        wdog_q <= '0;
      end else if (in_wait && !done_sel) begin
        wdog_q <= wdog_q + 1'b1;
      end
      if (in_wait && wait_expired) begin
        timeout_err_q <= 1'b1;
      end
    end
  end
`else
  assign wait_expired  = 1'b0;
  // TIMEOUT is always positive, so this is a constant 0: there is no watchdog.
  assign timeout_err_o = (TIMEOUT < 0);
`endif

  // Pass sequencer: state, pending mask, selected sprite and registered pulses.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      sel_q       <= 3'd0;
      start_q     <= '0;
      busy_q      <= 1'b0;
      pass_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // NOTE: pulses default low each cycle; branches below raise them for one cycle only.
      start_q     <= '0;
      pass_done_q <= 1'b0;

      if (frame_tick_i && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (frame_tick_i) begin
            pending_q <= sprite_en_i;
            busy_q    <= 1'b1;
            state_q   <= SELECT;
          end
        end
        SELECT: begin
          if (pending_q == '0) begin
            busy_q      <= 1'b0;
            pass_done_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            sel_q     <= low_idx;
            pending_q <= pending_q & ~low_mask;
            start_q   <= low_mask;
            state_q   <= E_START;
          end
        end
        E_START: state_q <= E_WAIT;
        E_WAIT: begin
          if (done_sel || wait_expired) begin
            start_q <= sel_mask;
            state_q <= D_START;
          end
        end
        D_START: state_q <= D_WAIT;
        D_WAIT: begin
          if (done_sel || wait_expired) begin
            state_q <= SELECT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The start pulse is also masked by reset itself so none leaves while reset is high.
  assign start_o     = reset_i ? '0 : start_q;
  assign sel_o       = sel_q;
  assign busy_o      = busy_q;
  assign pass_done_o = pass_done_q;
  assign overrun_o   = overrun_q;

  // NOTE: plot is deliberately combinational on done so the last pixel cycle is not over-written.
  assign plot_o   = in_wait && !done_sel;
  assign colour_o = ((state_q == D_START) || (state_q == D_WAIT)) ? DRAW_COLOUR : ERASE_COLOUR;
  assign plot_x_o = x_in_i[8*sel_q +: 8];
  assign plot_y_o = y_in_i[7*sel_q +: 7];

endmodule

// File: tb/tb_plot_scheduler.sv
// Testbench for plot_scheduler: sprite-unit models answer start pulses with a
// 13-pixel sequence; a scoreboard queue holds the expected start / pass_done
// events and a monitor checks each event, the pixel count of each phase, and
// colour / coordinates on every plot cycle.
module tb_plot_scheduler;
  localparam int NS   = 7;
  localparam int SEQ  = 13;

  logic            clk = 1'b0;
  logic            reset_i;
  logic            frame_tick_i;
  logic [NS-1:0]   sprite_en_i;
  logic [NS-1:0]   done_i;
  logic [8*NS-1:0] x_in_i;
  logic [7*NS-1:0] y_in_i;
  logic [NS-1:0]   start_o;
  logic [2:0]      sel_o;
  logic [7:0]      plot_x_o;
  logic [6:0]      plot_y_o;
  logic [2:0]      colour_o;
  logic            plot_o;
  logic            busy_o;
  logic            pass_done_o;
  logic            overrun_o;
  logic            timeout_err_o;

  always #5 clk = ~clk;

  plot_scheduler #(.NUM_SPRITES(NS)) dut (
    .clock_i(clk), .reset_i(reset_i), .frame_tick_i(frame_tick_i),
    .sprite_en_i(sprite_en_i), .done_i(done_i), .x_in_i(x_in_i), .y_in_i(y_in_i),
    .start_o(start_o), .sel_o(sel_o), .plot_x_o(plot_x_o), .plot_y_o(plot_y_o),
    .colour_o(colour_o), .plot_o(plot_o), .busy_o(busy_o), .pass_done_o(pass_done_o),
    .overrun_o(overrun_o), .timeout_err_o(timeout_err_o)
  );

  typedef struct {
    logic [NS-1:0] start;
    logic          pd;
    logic          draw;
    int            plots;
  } ev_t;

  ev_t           expq[$];
  int            total = 0;
  int            bad   = 0;
  int            mon_plots = 0;
  int            cur_idx   = 0;
  logic          cur_draw  = 1'b0;
  logic [NS-1:0] stuck     = '0;
  int            rem[NS]   = '{default: 0};
  logic [7:0]    xs[NS];
  logic [6:0]    ys[NS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sprite unit model: done drops on start and rises after SEQ pixel cycles.
  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (start_o[i]) rem[i] <= SEQ + 1;
      else if (rem[i] != 0) rem[i] <= rem[i] - 1;
    end
  end

  always_comb begin
    done_i = '0;
    for (int i = 0; i < NS; i++) done_i[i] = (rem[i] <= 1) && !stuck[i];
  end

  // Monitor: pops one expected event per start/pass_done and checks pixels.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (plot_o === 1'b1) begin
      mon_plots++;
      check("plot_pixel", {colour_o, plot_x_o, plot_y_o},
            {(cur_draw ? 3'b111 : 3'b000), xs[cur_idx], ys[cur_idx]});
    end
    if ((start_o != '0) || (pass_done_o === 1'b1)) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got start=%0h pass_done=%0b expected none",
                 start_o, pass_done_o);
      end else begin
        e = expq.pop_front();
        check("event", {pass_done_o, start_o}, {e.pd, e.start});
        check("phase_plots", mon_plots, e.plots);
        cur_draw = e.draw;
        for (int i = 0; i < NS; i++) if (e.start[i]) cur_idx = i;
        mon_plots = 0;
      end
    end
  end

  task automatic push_pass(input logic [NS-1:0] en, input int plots);
    ev_t e;
    bit  first = 1'b1;
    for (int i = 0; i < NS; i++) begin
      if (en[i]) begin
        e.start = NS'(1) << i;  e.pd = 1'b0;
        e.draw  = 1'b0;         e.plots = first ? 0 : plots;
        expq.push_back(e);
        e.draw  = 1'b1;         e.plots = plots;
        expq.push_back(e);
        first = 1'b0;
      end
    end
    e.start = '0; e.pd = 1'b1; e.draw = 1'b0; e.plots = first ? 0 : plots;
    expq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick_i = 1'b1;
    step(1);
    frame_tick_i = 1'b0;
  endtask

  task automatic wait_pd(input int maxc);
    int n = 0;
    while (pass_done_o !== 1'b1 && n < maxc) begin
      step(1);
      n++;
    end
    check("pass_done_seen", pass_done_o, 1'b1);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    check("start_during_reset", start_o, '0);
    step(1);
    reset_i = 1'b0;
    check("reset_outputs",
          {start_o, sel_o, plot_o, busy_o, pass_done_o, overrun_o, timeout_err_o}, '0);
    step(1);
    check("start_after_reset", start_o, '0);
  endtask

  initial begin
    reset_i      = 1'b1;
    frame_tick_i = 1'b0;
    sprite_en_i  = '0;
    for (int i = 0; i < NS; i++) begin
      xs[i] = 8'(8'h21 + i * 37);
      ys[i] = 7'(5 + i * 19);
      x_in_i[8*i +: 8] = xs[i];
      y_in_i[7*i +: 7] = ys[i];
    end
    step(2);
    do_reset();

    // Two sprites, latency to first start, mask change mid-pass ignored.
    sprite_en_i = 7'b0000101;
    push_pass(7'b0000101, SEQ);
    tick();
    check("busy_at_t1", {busy_o, start_o}, {1'b1, 7'b0});
    step(1);
    check("start_at_t2", {start_o, sel_o}, {7'b0000001, 3'd0});
    sprite_en_i = 7'b1111111;
    wait_pd(400);
    check("busy_after_pass", busy_o, 1'b0);

    // Empty mask: pass_done two cycles after the tick.
    sprite_en_i = '0;
    push_pass('0, 0);
    tick();
    check("empty_t1", {busy_o, pass_done_o, start_o}, {1'b1, 1'b0, 7'b0});
    step(1);
    check("empty_t2", {busy_o, pass_done_o}, {1'b0, 1'b1});
    step(1);
    check("empty_t3", pass_done_o, 1'b0);

    // Highest sprite, then a tick coincident with pass_done.
    sprite_en_i = 7'b1000000;
    push_pass(7'b1000000, SEQ);
    push_pass(7'b0000001, SEQ);
    tick();
    wait_pd(200);
    sprite_en_i = 7'b0000001;
    tick();
    check("coincident_busy", busy_o, 1'b1);
    step(1);
    check("coincident_start", start_o, 7'b0000001);
    wait_pd(200);

    // Overrun: second tick mid-pass is ignored, flag sticks until reset.
    sprite_en_i = 7'b0001000;
    push_pass(7'b0001000, SEQ);
    tick();
    step(4);
    check("overrun_before", overrun_o, 1'b0);
    tick();
    check("overrun_set", overrun_o, 1'b1);
    wait_pd(200);
    step(6);
    check("overrun_sticky", {overrun_o, busy_o}, {1'b1, 1'b0});
    do_reset();

    // Reset in the draw wait of sprite 3, then restart from lowest sprite.
    sprite_en_i = 7'b0011010;
    push_pass(7'b0011010, SEQ);
    tick();
    begin
      int n = 0;
      while (!(sel_o == 3'd3 && colour_o == 3'b111 && plot_o === 1'b1) && n < 300) begin
        step(1);
        n++;
      end
      check("reached_draw3", {sel_o, colour_o, plot_o}, {3'd3, 3'b111, 1'b1});
    end
    step(3);
    do_reset();
    expq.delete();
    mon_plots = 0;
    push_pass(7'b0011010, SEQ);
    tick();
    step(1);
    check("restart_lowest", start_o, 7'b0000010);
    wait_pd(400);

`ifdef PLOT_SCHED_TIMEOUT_EN
    // Unit 1 never finishes: each phase is forced after 32 wait cycles.
    stuck       = 7'b0000010;
    sprite_en_i = 7'b0000010;
    push_pass(7'b0000010, 32);
    tick();
    wait_pd(300);
    check("timeout_err", timeout_err_o, 1'b1);
    stuck = '0;
`else
    check("timeout_err_tied", timeout_err_o, 1'b0);
`endif

    step(3);
    check("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
